// File: rtl/mem_resp_scatter_pkg.sv
// Shared sizing constants and FSM encoding for the coalescer memory-response scatter path.
package mem_resp_scatter_pkg;

    localparam int SIZE_CORE              = 32;
    localparam int SIZE_CORE_LOG          = 5;
    localparam int SIZE_ADDR              = 32;
    localparam int SIZE_SEGMENT_BYTES_LOG = 6;
    localparam int WORD_BITS              = 32;

    typedef enum logic [1:0] {
        MRS_IDLE = 2'd0,
        MRS_BUSY = 2'd1,
        MRS_WB   = 2'd2
    } mrs_state_e;

endpackage

// File: rtl/mem_resp_scatter_seg_word_select.sv
// Picks one 32-bit word out of a returned memory segment; one instance per lane.
module seg_word_select #(
    parameter int SEG_LOG = 6,
    parameter int WORD_W  = 32
) (
    input  logic [(2**SEG_LOG)*8-1:0] data,
    input  logic [SEG_LOG-3:0]        idx,
    output logic [WORD_W-1:0]         word
);

    assign word = data[idx*WORD_W +: WORD_W];

endmodule

// File: rtl/mem_resp_scatter.sv
// Holds a warp's lane addresses, scatters segment responses into lanes, and presents the
// gathered vector for writeback once every active lane has been served.
module mem_resp_scatter
    import mem_resp_scatter_pkg::*;
#(
    parameter int NUM_LANES = SIZE_CORE,
    parameter int LANE_LOG  = SIZE_CORE_LOG,
    parameter int ADDR_W    = SIZE_ADDR,
    parameter int SEG_LOG   = SIZE_SEGMENT_BYTES_LOG,
    parameter int WORD_W    = WORD_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NUM_LANES-1:0]        req_mask,
    input  logic [NUM_LANES*ADDR_W-1:0] req_addr,
    input  logic                        rsp_valid,
    output logic                        rsp_ready,
    input  logic [ADDR_W-SEG_LOG-1:0]   rsp_seg,
    input  logic [(2**SEG_LOG)*8-1:0]   rsp_data,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [NUM_LANES-1:0]        wb_mask,
    output logic [NUM_LANES*WORD_W-1:0] wb_data,
    output logic                        err_stray
);

    // Byte offset within a word never matters, so only word addresses are kept.
    localparam int WA_W  = ADDR_W - 2;
    localparam int IDX_W = SEG_LOG - 2;

    mrs_state_e state_q, state_d;

    logic [NUM_LANES-1:0]             pending_q, lane_mask_q, hit;
    logic [NUM_LANES-1:0][WA_W-1:0]   waddr_q;
    logic [NUM_LANES-1:0][WORD_W-1:0] data_q, sel_word;
    logic                             stray_q, req_fire, rsp_fire;

    if ((1 << LANE_LOG) != NUM_LANES) begin : g_param_chk
        $error("NUM_LANES must equal 2**LANE_LOG");
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [1:0] unused_byte_off;
        assign unused_byte_off = req_addr[g*ADDR_W +: 2];
        assign hit[g] = pending_q[g] & (waddr_q[g][WA_W-1:IDX_W] == rsp_seg);

        seg_word_select #(.SEG_LOG(SEG_LOG), .WORD_W(WORD_W)) u_sel (
            .data (rsp_data),
            .idx  (waddr_q[g][IDX_W-1:0]),
            .word (sel_word[g])
        );
    end

    assign req_fire = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MRS_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_ready = 1'b0;
        wb_valid  = 1'b0;
        case (state_q)
            MRS_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = (req_mask == '0) ? MRS_WB : MRS_BUSY;
            end
            MRS_BUSY: begin
                rsp_ready = 1'b1;
                if (rsp_valid && ((pending_q & ~hit) == '0)) state_d = MRS_WB;
            end
            MRS_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = MRS_IDLE;
            end
            default: state_d = MRS_IDLE;
        endcase
    end

    // req_fire and rsp_fire are mutually exclusive: they live in different states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            lane_mask_q <= '0;
            waddr_q     <= '0;
            data_q      <= '0;
            stray_q     <= 1'b0;
        end else begin
            stray_q <= rsp_fire && (hit == '0);
            if (req_fire) begin
                pending_q   <= req_mask;
                lane_mask_q <= req_mask;
                data_q      <= '0;
                for (int i = 0; i < NUM_LANES; i++)
                    waddr_q[i] <= req_addr[i*ADDR_W+2 +: WA_W];
            end
            if (rsp_fire) begin
                pending_q <= pending_q & ~hit;
                for (int i = 0; i < NUM_LANES; i++)
                    if (hit[i]) data_q[i] <= sel_word[i];
            end
        end
    end

    assign wb_mask   = lane_mask_q;
    assign wb_data   = data_q;
    assign err_stray = stray_q;

endmodule
